// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 640x480 @ 60 Hz path: pixel/line counters,
// visible-area flag, delay-aligned sync, line/frame strobes and frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned PIPE_DELAY  = 1,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    output logic [9:0]             DrawX,
    output logic [9:0]             DrawY,
    output logic                   blank,
    output logic                   hs,
    output logic                   vs,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic             h_wrap_c;
    logic             v_wrap_c;
    logic [CNT_W-1:0] x_next_c;
    logic [CNT_W-1:0] y_next_c;
    logic             blank_next_c;
    logic             hs_next_c;
    logic             vs_next_c;
    logic             hs_raw;
    logic             vs_raw;

    // Next raster position and the attributes it will carry once registered.
    always_comb begin
        h_wrap_c     = (DrawX == CNT_W'(H_TOTAL - 1));
        v_wrap_c     = (DrawY == CNT_W'(V_TOTAL - 1));
        x_next_c     = h_wrap_c ? '0 : DrawX + CNT_W'(1);
        y_next_c     = DrawY;
        if (h_wrap_c) begin
            y_next_c = v_wrap_c ? '0 : DrawY + CNT_W'(1);
        end
        blank_next_c = (x_next_c < CNT_W'(H_VISIBLE)) && (y_next_c < CNT_W'(V_VISIBLE));
        hs_next_c    = ((x_next_c >= CNT_W'(HS_START)) && (x_next_c < CNT_W'(HS_END)))
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_next_c    = ((y_next_c >= CNT_W'(VS_START)) && (y_next_c < CNT_W'(VS_END)))
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Counters, strobes and undelayed sync all update on the same edge.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b1;
            hs_raw      <= ~SYNC_ACTIVE;
            vs_raw      <= ~SYNC_ACTIVE;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= x_next_c;
            DrawY       <= y_next_c;
            blank       <= blank_next_c;
            hs_raw      <= hs_next_c;
            vs_raw      <= vs_next_c;
            line_start  <= h_wrap_c;
            frame_start <= h_wrap_c && v_wrap_c;
            if (h_wrap_c && v_wrap_c) begin
                frame_count <= frame_count + FRAME_CNT_W'(1);
            end
        end
    end

    // Sync delay line keeps hs/vs aligned with downstream registered colour.
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] hs_pipe;
            logic [PIPE_DELAY-1:0] vs_pipe;

            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    hs_pipe <= {PIPE_DELAY{~SYNC_ACTIVE}};
                    vs_pipe <= {PIPE_DELAY{~SYNC_ACTIVE}};
                end else begin
                    hs_pipe[0] <= hs_raw;
                    vs_pipe[0] <= vs_raw;
                    for (int i = 1; i < int'(PIPE_DELAY); i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                    end
                end
            end

            assign hs = hs_pipe[PIPE_DELAY-1];
            assign vs = vs_pipe[PIPE_DELAY-1];
        end
    endgenerate

endmodule
